// File: rtl/blob_pkg.sv
// Shared types and constants for the blob centroid accumulator and its divider.
// The mask is a 48x64 binary image addressed row-major as y*48+x.
package blob_pkg;

    localparam int MASK_W      = 48;
    localparam int MASK_H      = 64;
    localparam int MASK_PIXELS = MASK_W * MASK_H;

    typedef logic [5:0]  coord_x_t;
    typedef logic [6:0]  coord_y_t;
    typedef logic [11:0] addr_t;
    typedef logic [11:0] count_t;
    typedef logic [17:0] sum_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ACCUM  = 3'd3,
        SETTLE = 3'd4,
        DIVIDE = 3'd5,
        DONE   = 3'd6
    } blob_state_t;

    typedef struct packed {
        blob_state_t state;
        logic [1:0]  div_busy;
        sum_t        quo_x;
        sum_t        quo_y;
        count_t      rem_x;
        count_t      rem_y;
    } blob_dbg_t;

    function automatic addr_t pix_addr(input coord_x_t x, input coord_y_t y);
        return addr_t'(y) * addr_t'(MASK_W) + addr_t'(x);
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle: 18-bit dividend by 12-bit divisor.
// start is accepted only when idle; done pulses for one cycle with quotient/remainder stable.
module serial_divider
    import blob_pkg::*;
(
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   start,
    input  sum_t   dividend,
    input  count_t divisor,
    output logic   busy,
    output logic   done,
    output sum_t   quotient,
    output count_t remainder
);

    logic [4:0]  bit_cnt;
    logic [12:0] trial;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial = {remainder, quotient[17]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy      <= 1'b1;
                quotient  <= dividend;
                remainder <= '0;
                bit_cnt   <= 5'd18;
            end else if (busy) begin
                if (trial >= {1'b0, divisor}) begin
                    remainder <= count_t'(trial - {1'b0, divisor});
                    quotient  <= {quotient[16:0], 1'b1};
                end else begin
                    remainder <= trial[11:0];
                    quotient  <= {quotient[16:0], 1'b0};
                end
                bit_cnt <= bit_cnt - 5'd1;
                if (bit_cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/blob_centroid_accumulator.sv
// Walks the 48x64 mask via the scan sequencer, accumulating count, coordinate sums
// and bounding box; at frame end divides the sums to report the blob centroid.
module blob_centroid_accumulator
    import blob_pkg::*;
#(
    parameter int BRAM_LAT  = 2,
    parameter int MIN_COUNT = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        blob_trigger_in,
    input  logic [5:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic        frame_end_in,
    input  logic        mask_data_in,
    output logic [11:0] mask_addr_out,
    output logic        new_pixel_out,
    output logic [11:0] pixel_count_out,
    output logic [5:0]  centroid_x_out,
    output logic [6:0]  centroid_y_out,
    output logic [5:0]  bbox_x_min_out,
    output logic [5:0]  bbox_x_max_out,
    output logic [6:0]  bbox_y_min_out,
    output logic [6:0]  bbox_y_max_out,
    output logic        blob_found_out,
    output logic        result_valid_out,
    output blob_dbg_t   dbg
);

    localparam count_t     COUNT_MIN = count_t'(MIN_COUNT);
    localparam logic [3:0] WAIT_LAST = 4'(BRAM_LAT - 1);

    blob_state_t state;
    coord_x_t    x_q, x_min_q, x_max_q;
    coord_y_t    y_q, y_min_q, y_max_q;
    count_t      count_q;
    sum_t        sum_x_q, sum_y_q;
    logic [3:0]  wait_cnt;
    logic        div_start, div_go;

    sum_t   quo_x, quo_y;
    count_t rem_x, rem_y;
    logic   div_x_busy, div_y_busy, div_x_done, div_y_done;

    serial_divider u_div_x (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start     (div_start),
        .dividend  (sum_x_q),
        .divisor   (count_q),
        .busy      (div_x_busy),
        .done      (div_x_done),
        .quotient  (quo_x),
        .remainder (rem_x)
    );

    serial_divider u_div_y (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start     (div_start),
        .dividend  (sum_y_q),
        .divisor   (count_q),
        .busy      (div_y_busy),
        .done      (div_y_done),
        .quotient  (quo_y),
        .remainder (rem_y)
    );

    assign dbg = '{state: state, div_busy: {div_y_busy, div_x_busy},
                   quo_x: quo_x, quo_y: quo_y, rem_x: rem_x, rem_y: rem_y};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            x_q              <= '0;
            y_q              <= '0;
            x_min_q          <= '0;
            x_max_q          <= '0;
            y_min_q          <= '0;
            y_max_q          <= '0;
            count_q          <= '0;
            sum_x_q          <= '0;
            sum_y_q          <= '0;
            wait_cnt         <= '0;
            div_start        <= 1'b0;
            div_go           <= 1'b0;
            mask_addr_out    <= '0;
            new_pixel_out    <= 1'b0;
            pixel_count_out  <= '0;
            centroid_x_out   <= '0;
            centroid_y_out   <= '0;
            bbox_x_min_out   <= '0;
            bbox_x_max_out   <= '0;
            bbox_y_min_out   <= '0;
            bbox_y_max_out   <= '0;
            blob_found_out   <= 1'b0;
            result_valid_out <= 1'b0;
        end else begin
            new_pixel_out    <= 1'b0;
            result_valid_out <= 1'b0;
            div_start        <= 1'b0;
            case (state)
                IDLE: begin
                    if (blob_trigger_in) begin
                        count_q <= '0;
                        sum_x_q <= '0;
                        sum_y_q <= '0;
                        x_min_q <= coord_x_t'(MASK_W - 1);
                        y_min_q <= coord_y_t'(MASK_H - 1);
                        x_max_q <= '0;
                        y_max_q <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    x_q           <= x_in;
                    y_q           <= y_in;
                    mask_addr_out <= pix_addr(x_in, y_in);
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // Request is raised on entry to ACCUM so the sequencer
                    // advances at the end of ACCUM and is stable in SETTLE.
                    if (wait_cnt == WAIT_LAST) begin
                        new_pixel_out <= 1'b1;
                        state         <= ACCUM;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACCUM: begin
                    if (mask_data_in) begin
                        count_q <= count_q + 12'd1;
                        sum_x_q <= sum_x_q + sum_t'(x_q);
                        sum_y_q <= sum_y_q + sum_t'(y_q);
                        if (x_q < x_min_q) x_min_q <= x_q;
                        if (x_q > x_max_q) x_max_q <= x_q;
                        if (y_q < y_min_q) y_min_q <= y_q;
                        if (y_q > y_max_q) y_max_q <= y_q;
                    end
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= frame_end_in ? DIVIDE : FETCH;
                end
                DIVIDE: begin
                    if (count_q < COUNT_MIN) begin
                        state <= DONE;
                    end else if (!div_go) begin
                        div_start <= 1'b1;
                        div_go    <= 1'b1;
                    end else if (div_x_done && div_y_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    pixel_count_out  <= count_q;
                    result_valid_out <= 1'b1;
                    div_go           <= 1'b0;
                    if (count_q >= COUNT_MIN) begin
                        centroid_x_out <= quo_x[5:0];
                        centroid_y_out <= quo_y[6:0];
                        bbox_x_min_out <= x_min_q;
                        bbox_x_max_out <= x_max_q;
                        bbox_y_min_out <= y_min_q;
                        bbox_y_max_out <= y_max_q;
                        blob_found_out <= 1'b1;
                    end else begin
                        centroid_x_out <= '0;
                        centroid_y_out <= '0;
                        bbox_x_min_out <= '0;
                        bbox_x_max_out <= '0;
                        bbox_y_min_out <= '0;
                        bbox_y_max_out <= '0;
                        blob_found_out <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_centroid_accumulator.sv
// Directed bench: two instances (MIN_COUNT 16 and 1) share a modelled scan sequencer;
// each has its own 2-cycle mask BRAM model. Frame results are checked against hand values.
module tb_blob_centroid_accumulator;
    import blob_pkg::*;

    typedef struct packed {
        logic [11:0] count;
        logic [5:0]  cx;
        logic [6:0]  cy;
        logic [5:0]  xmin;
        logic [5:0]  xmax;
        logic [6:0]  ymin;
        logic [6:0]  ymax;
        logic        found;
    } res_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        blob_trigger_in = 1'b0;
    logic        frame_end_in;
    logic [5:0]  x_in;
    logic [6:0]  y_in;
    logic        mask_data0, mask_data1;

    logic [11:0] mask_addr0, mask_addr1, pixel_count0, pixel_count1;
    logic        new_pixel0, new_pixel1, found0, found1, result_valid0, result_valid1;
    logic [5:0]  centroid_x0, centroid_x1, bbox_x_min0, bbox_x_min1, bbox_x_max0, bbox_x_max1;
    logic [6:0]  centroid_y0, centroid_y1, bbox_y_min0, bbox_y_min1, bbox_y_max0, bbox_y_max1;
    blob_dbg_t   dbg0, dbg1;

    logic mask_mem [0:MASK_PIXELS-1];

    int   n_vec, n_err;
    int   np0_cnt, np1_cnt, rv0_cnt, rv1_cnt, addr_errs;
    res_t res0, res1;

    always #5 clk_in = ~clk_in;

    blob_centroid_accumulator dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .blob_trigger_in(blob_trigger_in),
        .x_in(x_in), .y_in(y_in), .frame_end_in(frame_end_in), .mask_data_in(mask_data0),
        .mask_addr_out(mask_addr0), .new_pixel_out(new_pixel0), .pixel_count_out(pixel_count0),
        .centroid_x_out(centroid_x0), .centroid_y_out(centroid_y0),
        .bbox_x_min_out(bbox_x_min0), .bbox_x_max_out(bbox_x_max0),
        .bbox_y_min_out(bbox_y_min0), .bbox_y_max_out(bbox_y_max0),
        .blob_found_out(found0), .result_valid_out(result_valid0), .dbg(dbg0)
    );

    blob_centroid_accumulator #(.MIN_COUNT(1)) dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .blob_trigger_in(blob_trigger_in),
        .x_in(x_in), .y_in(y_in), .frame_end_in(frame_end_in), .mask_data_in(mask_data1),
        .mask_addr_out(mask_addr1), .new_pixel_out(new_pixel1), .pixel_count_out(pixel_count1),
        .centroid_x_out(centroid_x1), .centroid_y_out(centroid_y1),
        .bbox_x_min_out(bbox_x_min1), .bbox_x_max_out(bbox_x_max1),
        .bbox_y_min_out(bbox_y_min1), .bbox_y_max_out(bbox_y_max1),
        .blob_found_out(found1), .result_valid_out(result_valid1), .dbg(dbg1)
    );

    // Scan sequencer and mask BRAM models: sample at negedge, drive #1 after posedge.
    initial begin : seq
        logic        np, trig, running, d0p, d1p;
        logic [11:0] a0, a1;
        x_in = '0; y_in = '0; frame_end_in = 1'b0;
        mask_data0 = 1'b0; mask_data1 = 1'b0;
        running = 1'b0; d0p = 1'b0; d1p = 1'b0;
        forever begin
            @(negedge clk_in);
            np = new_pixel0; trig = blob_trigger_in; a0 = mask_addr0; a1 = mask_addr1;
            @(posedge clk_in);
            #1;
            if (!rst_n_in) begin
                x_in = '0; y_in = '0; frame_end_in = 1'b0; running = 1'b0;
                mask_data0 = 1'b0; mask_data1 = 1'b0; d0p = 1'b0; d1p = 1'b0;
            end else begin
                mask_data0 = d0p; d0p = mask_mem[a0];
                mask_data1 = d1p; d1p = mask_mem[a1];
                frame_end_in = 1'b0;
                if (trig && !running) running = 1'b1;
                if (np && running) begin
                    if (x_in == 6'd47) begin
                        x_in = '0;
                        if (y_in == 7'd63) begin
                            y_in = '0; frame_end_in = 1'b1; running = 1'b0;
                        end else begin
                            y_in = y_in + 7'd1;
                        end
                    end else begin
                        x_in = x_in + 6'd1;
                    end
                end
            end
        end
    end

    initial begin : mon
        np0_cnt = 0; np1_cnt = 0; rv0_cnt = 0; rv1_cnt = 0; addr_errs = 0;
        res0 = '0; res1 = '0;
        forever begin
            @(negedge clk_in);
            if (new_pixel0) begin
                np0_cnt++;
                if (mask_addr0 !== 12'(int'(y_in) * 48 + int'(x_in))) addr_errs++;
            end
            if (new_pixel1) begin
                np1_cnt++;
                if (mask_addr1 !== 12'(int'(y_in) * 48 + int'(x_in))) addr_errs++;
            end
            if (result_valid0) begin
                rv0_cnt++;
                res0 = '{pixel_count0, centroid_x0, centroid_y0, bbox_x_min0, bbox_x_max0,
                         bbox_y_min0, bbox_y_max0, found0};
            end
            if (result_valid1) begin
                rv1_cnt++;
                res1 = '{pixel_count1, centroid_x1, centroid_y1, bbox_x_min1, bbox_x_max1,
                         bbox_y_min1, bbox_y_max1, found1};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t got, input res_t exp);
        chk({tag, ".count"}, 32'(got.count), 32'(exp.count));
        chk({tag, ".cx"},    32'(got.cx),    32'(exp.cx));
        chk({tag, ".cy"},    32'(got.cy),    32'(exp.cy));
        chk({tag, ".xmin"},  32'(got.xmin),  32'(exp.xmin));
        chk({tag, ".xmax"},  32'(got.xmax),  32'(exp.xmax));
        chk({tag, ".ymin"},  32'(got.ymin),  32'(exp.ymin));
        chk({tag, ".ymax"},  32'(got.ymax),  32'(exp.ymax));
        chk({tag, ".found"}, 32'(got.found), 32'(exp.found));
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        for (int i = 0; i < MASK_PIXELS; i++) mask_mem[i] = 1'b0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) mask_mem[y * 48 + x] = 1'b1;
    endtask

    task automatic pulse_trigger();
        @(posedge clk_in);
        #1 blob_trigger_in = 1'b1;
        @(posedge clk_in);
        #1 blob_trigger_in = 1'b0;
    endtask

    // Waits for one frame result, lets the bus go quiet, then checks everything.
    task automatic finish_frame(input string tag, input int np0_b, input int np1_b,
                                input int rv0_b, input int rv1_b, input res_t e0, input res_t e1);
        int cyc;
        cyc = 0;
        while (rv0_cnt == rv0_b && cyc < 16000) begin
            @(negedge clk_in);
            cyc++;
        end
        repeat (30) @(negedge clk_in);
        chk({tag, ".rv0_pulses"}, 32'(rv0_cnt - rv0_b), 32'd1);
        chk({tag, ".rv1_pulses"}, 32'(rv1_cnt - rv1_b), 32'd1);
        chk({tag, ".np0_pulses"}, 32'(np0_cnt - np0_b), 32'd3072);
        chk({tag, ".np1_pulses"}, 32'(np1_cnt - np1_b), 32'd3072);
        chk({tag, ".addr_errs"},  32'(addr_errs), 32'd0);
        chk_res({tag, ".dut0"}, res0, e0);
        chk_res({tag, ".dut1"}, res1, e1);
        chk({tag, ".hold_count0"}, 32'(pixel_count0), 32'(e0.count));
        chk({tag, ".hold_cx1"},    32'(centroid_x1),  32'(e1.cx));
    endtask

    initial begin : main
        int   np0_b, np1_b, rv0_b, rv1_b, cyc;
        res_t zero_res;
        n_vec = 0; n_err = 0;
        zero_res = '0;
        set_rect(1, 0, 1, 0);

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("reset.state0",  32'(dbg0.state),    32'(IDLE));
        chk("reset.count0",  32'(pixel_count0),  32'd0);
        chk("reset.valid0",  32'(result_valid0), 32'd0);
        chk("reset.np0",     32'(new_pixel0),    32'd0);
        chk("reset.addr0",   32'(mask_addr0),    32'd0);
        chk("reset.found0",  32'(found0),        32'd0);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        // A: empty mask
        np0_b = np0_cnt; np1_b = np1_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        finish_frame("empty", np0_b, np1_b, rv0_b, rv1_b, zero_res, zero_res);

        // B: 4x4 rectangle exactly at MIN_COUNT, with a second trigger mid-scan
        set_rect(4, 7, 10, 13);
        np0_b = np0_cnt; np1_b = np1_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        cyc = 0;
        while (np0_cnt - np0_b < 100 && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
        end
        pulse_trigger();
        finish_frame("rect16", np0_b, np1_b, rv0_b, rv1_b,
                     res_t'{12'd16, 6'd5, 7'd11, 6'd4, 6'd7, 7'd10, 7'd13, 1'b1},
                     res_t'{12'd16, 6'd5, 7'd11, 6'd4, 6'd7, 7'd10, 7'd13, 1'b1});

        // C: single pixel at (10,20)
        set_rect(10, 10, 20, 20);
        np0_b = np0_cnt; np1_b = np1_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        finish_frame("single", np0_b, np1_b, rv0_b, rv1_b,
                     res_t'{12'd1, 6'd0, 7'd0, 6'd0, 6'd0, 7'd0, 7'd0, 1'b0},
                     res_t'{12'd1, 6'd10, 7'd20, 6'd10, 6'd10, 7'd20, 7'd20, 1'b1});

        // D: full mask
        set_rect(0, 47, 0, 63);
        np0_b = np0_cnt; np1_b = np1_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        finish_frame("full", np0_b, np1_b, rv0_b, rv1_b,
                     res_t'{12'd3072, 6'd23, 7'd31, 6'd0, 6'd47, 7'd0, 7'd63, 1'b1},
                     res_t'{12'd3072, 6'd23, 7'd31, 6'd0, 6'd47, 7'd0, 7'd63, 1'b1});

        // E: reset asserted at pixel 1000 aborts the scan
        set_rect(4, 7, 10, 13);
        np0_b = np0_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        cyc = 0;
        while (np0_cnt - np0_b < 1000 && cyc < 8000) begin
            @(negedge clk_in);
            cyc++;
        end
        chk("abort.reached_1000", 32'(np0_cnt - np0_b), 32'd1000);
        #2 rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("abort.state0",  32'(dbg0.state),    32'(IDLE));
        chk("abort.count0",  32'(pixel_count0),  32'd0);
        chk("abort.cx1",     32'(centroid_x1),   32'd0);
        chk("abort.found1",  32'(found1),        32'd0);
        repeat (4) @(negedge clk_in);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        repeat (200) @(negedge clk_in);
        chk("abort.no_rv0", 32'(rv0_cnt - rv0_b), 32'd0);
        chk("abort.no_rv1", 32'(rv1_cnt - rv1_b), 32'd0);

        // F: 5x3 rectangle, one below MIN_COUNT for dut0
        set_rect(4, 8, 10, 12);
        np0_b = np0_cnt; np1_b = np1_cnt; rv0_b = rv0_cnt; rv1_b = rv1_cnt;
        pulse_trigger();
        finish_frame("rect15", np0_b, np1_b, rv0_b, rv1_b,
                     res_t'{12'd15, 6'd0, 7'd0, 6'd0, 6'd0, 7'd0, 7'd0, 1'b0},
                     res_t'{12'd15, 6'd6, 7'd11, 6'd4, 6'd8, 7'd10, 7'd12, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
